// File: rtl/uart_rx_byte.sv
// uart_rx_byte: 8N1 UART receiver with mid-bit sampling, one-cycle valid strobe and stop-bit error flag
module uart_rx_byte #(
  parameter int CLKFREQ   = 100_000_000,
  parameter int BAUDRATE  = 115200,
  parameter int CNT_WIDTH = 14
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rxd,
  output logic [7:0] rxData,
  output logic       rxValid,
  output logic       frameErr,
  output logic       busy
);
  localparam int BIT_CYC = CLKFREQ / BAUDRATE;
  localparam int HALF    = BIT_CYC >> 1;
  localparam logic [CNT_WIDTH-1:0] BIT_LAST  = CNT_WIDTH'(BIT_CYC - 1);
  localparam logic [CNT_WIDTH-1:0] HALF_LAST = CNT_WIDTH'(HALF - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t               state, state_n;
  logic                 rx_m, rx_s, rx_s_d1, armed, fall;
  logic [1:0]           fill;
  logic [CNT_WIDTH-1:0] cnt, cnt_n;
  logic [2:0]           idx, idx_n;
  logic [7:0]           shift, shift_n, data_n;
  logic                 valid_n, ferr_n;

  // Synchroniser, delayed copy for edge detection; start edges are armed only once the
  // real line (not the reset-loaded ones) has been seen high, so a line held low across
  // reset release never fakes a start bit.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_m    <= 1'b1;
      rx_s    <= 1'b1;
      rx_s_d1 <= 1'b1;
      fill    <= 2'b00;
      armed   <= 1'b0;
    end else begin
      rx_m    <= rxd;
      rx_s    <= rx_m;
      rx_s_d1 <= rx_s;
      fill    <= {fill[0], 1'b1};
      armed   <= armed | (fill[1] & rx_s);
    end
  end

  assign fall = armed & ~rx_s & rx_s_d1;

  // State, counter, shift register and registered outputs
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      idx      <= '0;
      shift    <= '0;
      rxData   <= '0;
      rxValid  <= 1'b0;
      frameErr <= 1'b0;
      busy     <= 1'b0;
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      idx      <= idx_n;
      shift    <= shift_n;
      rxData   <= data_n;
      rxValid  <= valid_n;
      frameErr <= ferr_n;
      busy     <= state_n != IDLE;
    end
  end

  // Next-state logic: mid-bit sampling of start, eight data bits and stop bit
  always_comb begin
    state_n = state;
    cnt_n   = cnt + 1'b1;
    idx_n   = idx;
    shift_n = shift;
    data_n  = rxData;
    valid_n = 1'b0;
    ferr_n  = 1'b0;
    case (state)
      IDLE: begin
        cnt_n   = '0;
        state_n = fall ? START : IDLE;
      end
      START: if (cnt == HALF_LAST) begin
        cnt_n   = '0;
        idx_n   = '0;
        state_n = rx_s ? IDLE : DATA;
      end
      DATA: if (cnt == BIT_LAST) begin
        cnt_n          = '0;
        shift_n[idx]   = rx_s;
        idx_n          = idx + 3'd1;
        state_n        = (idx == 3'd7) ? STOP : DATA;
      end
      STOP: if (cnt == BIT_LAST) begin
        cnt_n   = '0;
        state_n = IDLE;
        valid_n = rx_s;
        ferr_n  = ~rx_s;
        data_n  = rx_s ? shift : rxData;
      end
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_uart_rx_byte.sv
// tb_uart_rx_byte: randomized and directed serial frames checked cycle by cycle against a timing model of the receiver
module tb_uart_rx_byte;
  localparam int B = 868;
  localparam int H = 434;
  localparam int MAXC = 100000;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       rxd = 1'b1;
  logic [7:0] rxData;
  logic       rxValid, frameErr, busy;

  int checks = 0, errors = 0, cyc = 0, fs = 0;
  int n_valid = 0, n_ferr = 0, n_busy = 0;
  int tq[$];
  logic [7:0] vq[$];

  bit line [0:MAXC-1];
  bit rst_line [0:MAXC-1];
  bit act = 1'b0;
  int f = 0, rlast = 0;
  logic [7:0] e_data;
  logic e_valid, e_ferr;

  uart_rx_byte dut (
    .clk(clk), .reset(reset), .rxd(rxd),
    .rxData(rxData), .rxValid(rxValid), .frameErr(frameErr), .busy(busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h want %0h", name, cyc, got, want);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rxd = 1'b1;
    repeat (n) tick();
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    fs = cyc;
    for (int i = 0; i < 10; i++) begin
      rxd = bits[i];
      repeat (B) tick();
    end
  endtask

  // Model: line[m] is the level driven just after posedge m. A frame starts from a 1->0
  // line transition at f (both levels driven after the last reset), is seen 3 cycles
  // later, samples bit j at line[f+H+j*B], and reports H+9B+3 cycles after f.
  initial begin
    int m;
    forever begin
      @(negedge clk);
      m = cyc;
      if (m >= MAXC) begin
        $display("FAIL cycle_budget exceeded at %0d", m);
        $fatal(1);
      end
      line[m]     = rxd;
      rst_line[m] = reset;
      e_valid = 1'b0;
      e_ferr  = 1'b0;
      if (m >= 1 && !rst_line[m-1]) begin
        act    = 1'b0;
        e_data = 8'h00;
        rlast  = m;
      end else if (act) begin
        if (m == f + 3 + H && line[f+H]) act = 1'b0;
        else if (m == f + 3 + H + 9 * B) begin
          act = 1'b0;
          if (line[f+H+9*B]) begin
            e_valid = 1'b1;
            for (int j = 0; j < 8; j++) e_data[j] = line[f+H+(j+1)*B];
          end else e_ferr = 1'b1;
        end
      end else if (m - 4 >= rlast && line[m-4] && !line[m-3]) begin
        act = 1'b1;
        f   = m - 3;
      end
      chk("rxValid", rxValid, e_valid);
      chk("frameErr", frameErr, e_ferr);
      chk("busy", busy, act);
      chk("rxData", rxData, e_data);
      if (rxValid === 1'b1) begin
        n_valid++;
        vq.push_back(rxData);
        tq.push_back(m);
      end
      if (frameErr === 1'b1) n_ferr++;
      if (busy === 1'b1) n_busy++;
    end
  end

  initial begin
    int v0, e0, b0, k0;
    logic [7:0] rb, prev;
    logic rs;
    reset = 1'b0;
    rxd   = 1'b1;
    repeat (3) tick();
    chk("reset_rxData", rxData, 8'h00);
    chk("reset_rxValid", rxValid, 1'b0);
    chk("reset_frameErr", frameErr, 1'b0);
    chk("reset_busy", busy, 1'b0);
    reset = 1'b1;
    idle(50);

    v0 = n_valid; e0 = n_ferr; b0 = n_busy;
    send_frame(8'h55, 1'b1);
    idle(20);
    chk("t1_valid_count", n_valid - v0, 1);
    chk("t1_ferr_count", n_ferr - e0, 0);
    chk("t1_rxData", rxData, 8'h55);
    chk("t1_busy_cycles", n_busy - b0, 8246);
    chk("t1_latency", tq[tq.size()-1] - fs, 8249);

    v0 = n_valid; e0 = n_ferr;
    send_frame(8'hFF, 1'b0);
    idle(20);
    chk("t4_ferr_count", n_ferr - e0, 1);
    chk("t4_valid_count", n_valid - v0, 0);
    chk("t4_rxData", rxData, 8'h55);

    v0 = n_valid; k0 = vq.size();
    send_frame(8'hA3, 1'b1);
    send_frame(8'h00, 1'b1);
    idle(20);
    chk("t2_valid_count", n_valid - v0, 2);
    chk("t2_first", vq[k0], 8'hA3);
    chk("t2_second", vq[k0+1], 8'h00);
    chk("t2_gap", tq[k0+1] - tq[k0], 8680);

    v0 = n_valid; e0 = n_ferr; b0 = n_busy;
    rxd   = 1'b0;
    reset = 1'b0;
    repeat (3) tick();
    reset = 1'b1;
    repeat (5000) tick();
    idle(100);
    send_frame(8'h81, 1'b1);
    idle(20);
    chk("t6_valid_count", n_valid - v0, 1);
    chk("t6_ferr_count", n_ferr - e0, 0);
    chk("t6_rxData", rxData, 8'h81);
    chk("t6_busy_cycles", n_busy - b0, 8246);

    v0 = n_valid;
    rb = 8'h96;
    fs = cyc;
    rxd = 1'b0;
    repeat (B) tick();
    for (int i = 0; i < 4; i++) begin
      rxd = rb[i];
      repeat (B) tick();
    end
    rxd = rb[4];
    repeat (H) tick();
    chk("t5_busy_before", busy, 1'b1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk("t5_rxData", rxData, 8'h00);
    chk("t5_rxValid", rxValid, 1'b0);
    chk("t5_frameErr", frameErr, 1'b0);
    chk("t5_busy", busy, 1'b0);
    idle(200);
    send_frame(8'h3C, 1'b1);
    idle(20);
    chk("t5_valid_count", n_valid - v0, 1);
    chk("t5_next_rxData", rxData, 8'h3C);

    v0 = n_valid; e0 = n_ferr; b0 = n_busy;
    rxd = 1'b0;
    repeat (200) tick();
    idle(1000);
    chk("t3_valid_count", n_valid - v0, 0);
    chk("t3_ferr_count", n_ferr - e0, 0);
    chk("t3_busy_cycles", n_busy - b0, H);

    for (int r = 0; r < 2; r++) begin
      rb = 8'($urandom);
      rs = ($urandom_range(0, 3) != 0);
      prev = rxData;
      v0 = n_valid; e0 = n_ferr;
      idle($urandom_range(1, 50));
      send_frame(rb, rs);
      idle(20);
      chk("rand_valid_count", n_valid - v0, rs ? 1 : 0);
      chk("rand_ferr_count", n_ferr - e0, rs ? 0 : 1);
      chk("rand_rxData", rxData, rs ? rb : prev);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
